ab_seq_gen: RTL
===============

# ab_seq_gen

- Stimulus generator for the two-input (`a`, `b`) sequence-detector FSM that asserts `y` after an XOR → AND → OR symbol walk.
- On a `start` request it transmits one complete frame: one XOR symbol, one AND symbol, a programmable-length OR run, then one idle gap symbol.
- Drives detector inputs in block-level benches and in the lab top-level.
- Optionally produces the cycle-exact `y` the detector must show.

## Interface

Parameters:
- `HOLD_W`, default 4, width of the OR-run length field.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only when `busy`=0.
- `pol`  in  1  XOR-symbol selector, latched at accept: 0 → (a,b)=10, 1 → 01.
- `hold_len`  in  HOLD_W  OR-run length minus one, latched at accept.
- `abort`  in  1  synchronous frame cancel.
- `a`, `b`  out  1 each  registered symbol outputs.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse in the gap cycle.
- `y_exp`  out  1  expected detector `y`; present only with the config macro.

## Operation

- States: IDLE, XOR, AND, OR, GAP.
- Output (a,b) per state, all registered:
  - IDLE: 00.
  - XOR: 10 if `pol`=0, 01 if `pol`=1.
  - AND: 11.
  - OR: rotating 10, 01, 11, 10, … starting at 10.
  - GAP: 00.
- Transitions:
  - IDLE → XOR on `start`; latch `pol` and `hold_len`.
  - XOR → AND; AND → OR, loading the hold counter with `hold_len`.
  - OR: stay while counter ≠ 0, decrementing each cycle; → GAP when counter = 0.
  - GAP → IDLE unconditionally.
- OR run length is `hold_len`+1 cycles (1 … 2^HOLD_W). Counter is unsigned and never wraps below 0.
- Rotation index is 2-bit modulo 3 and resets to 0 on entry to OR.
- `busy`=1 in XOR, AND, OR, GAP.
- `done`=1 only in GAP.
- `start` while `busy`=1 is ignored. It is not queued.
- `abort` in any busy state: next state IDLE, (a,b)=00, no `done`.
- `abort` and `start` in the same IDLE cycle: `start` is accepted.
- Frame length is `hold_len`+4 cycles from the first XOR cycle through GAP.

## Timing

- Reset values: state IDLE; `a`=`b`=`busy`=`done`=`y_exp`=0; counters 0. Reset takes effect immediately, including mid-frame.
- Latency: `start` sampled at edge N → XOR symbol visible after edge N, with `busy`=1 in the same cycle.
- Back-to-back frames: earliest accepted `start` is the IDLE cycle after GAP. Minimum frame-to-frame spacing is `hold_len`+5 cycles.
- `pol`, `hold_len`: don't-care except at the accepting edge.

## Configuration

- Macro `AB_SEQ_GEN_YEXP_EN`.
- Defined: the `y_exp` port and an embedded detector model are compiled in.
  - The model holds 2-bit state S0–S3 with the detector's transitions, fed from the registered `a`,`b`.
  - `y_exp` = model state ∈ {S1, S2}.
  - For a full frame, `y_exp`=1 exactly in the AND cycle and the first OR cycle.
  - Model resets with `reset`.
- Undefined: no `y_exp` port and no model logic.

## Structure

- Package `ab_seq_pkg` holds:
  - the state enum typedef (IDLE, XOR, AND, OR, GAP);
  - 2-bit symbol constants SYM_IDLE=00, SYM_A=10, SYM_B=01, SYM_AB=11;
  - the detector-model state typedef S0–S3.
- One sub-module, `ab_seq_hold_ctr`: a loadable HOLD_W-bit down-counter with `load`, `dec`, and a `zero` flag.

## Test plan

- Reset, `start`=1, `pol`=0, `hold_len`=2 → (a,b)=10,11,10,01,11,00 over 6 cycles; `busy` high for those 6 cycles; `done` only in cycle 6.
- `pol`=1, `hold_len`=0 → 01,11,10,00; with `AB_SEQ_GEN_YEXP_EN`, `y_exp`=0,1,1,0.
- `hold_len`=15 (HOLD_W=4) → OR run exactly 16 cycles, rotation 10,01,11 repeating; GAP follows; no counter wrap.
- `start` pulsed every cycle → frames separated by exactly one IDLE cycle; mid-frame `start` ignored.
- `abort` in the 2nd OR cycle → next cycle (a,b)=00, `busy`=0, no `done` pulse.
- `reset` asserted asynchronously mid-AND → `a`,`b`,`busy` drop to 0 before the next edge; next `start` yields a normal frame.

Source files
------------

// File: rtl/ab_seq_pkg.sv
// ab_seq_pkg: shared types and symbol constants for the a/b sequence generator
// Contents: generator state enum, 2-bit (a,b) symbol codes, detector-model state enum,
// and the OR-run rotation lookup.
package ab_seq_pkg;
  typedef enum logic [2:0] {IDLE, XOR, AND, OR, GAP} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_A    = 2'b10;
  localparam logic [1:0] SYM_B    = 2'b01;
  localparam logic [1:0] SYM_AB   = 2'b11;
  function automatic logic [1:0] rot_sym(input logic [1:0] i);
    return i == 2'd0 ? SYM_A : i == 2'd1 ? SYM_B : SYM_AB;
  endfunction
endpackage

// File: rtl/ab_seq_hold_ctr.sv
// ab_seq_hold_ctr: loadable down-counter timing the OR run
// Ports: clk, reset (async, active-high), load/din (load value), dec (decrement,
// saturates at 0), cnt (current value), zero (cnt == 0).
module ab_seq_hold_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/ab_seq_gen.sv
// ab_seq_gen: frame generator driving XOR -> AND -> OR-run -> gap symbols into a detector
// Ports: clk, reset (async, active-high), start (frame request, idle only), pol (XOR symbol
// select), hold_len (OR run length - 1), abort (cancel frame), a/b (registered symbol),
// busy (frame in progress), done (gap-cycle pulse), y_exp (expected detector y, only when
// AB_SEQ_GEN_YEXP_EN is defined, together with the embedded detector model).
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pol,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              busy,
`ifdef AB_SEQ_GEN_YEXP_EN
  output logic              y_exp,
`endif
  output logic              done
);
  state_t state, state_n;
  logic [1:0] rot, rot_n, sym_n;
  logic [HOLD_W-1:0] cnt;
  logic zero, accept;
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == GAP;
  // The counter captures hold_len at accept and only counts down in OR, so it still
  // holds the accepted length on entry to OR and no separate length latch is needed.
  ab_seq_hold_ctr #(.W(HOLD_W)) u_ctr (
    .clk(clk), .reset(reset), .load(accept), .dec(state == OR),
    .din(hold_len), .cnt(cnt), .zero(zero)
  );
  always_comb begin
    state_n = state == IDLE ? (start ? XOR : IDLE) :
              abort         ? IDLE :
              state == XOR  ? AND :
              state == AND  ? OR :
              state == OR   ? (zero ? GAP : OR) : IDLE;
    rot_n = (state != OR || state_n != OR || rot == 2'd2) ? 2'd0 : rot + 2'd1;
    // XOR is only entered from IDLE, so the live pol at the accepting edge is the latched one.
    sym_n = state_n == XOR ? (pol ? SYM_B : SYM_A) :
            state_n == AND ? SYM_AB :
            state_n == OR  ? rot_sym(rot_n) : SYM_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      rot    <= 2'd0;
      {a, b} <= SYM_IDLE;
    end else begin
      state  <= state_n;
      rot    <= rot_n;
      {a, b} <= sym_n;
    end
`ifdef AB_SEQ_GEN_YEXP_EN
  det_t det, det_n;
  // Detector model: S1 after an XOR symbol, S2 after XOR then AND, S3 parks through the
  // rest of the non-idle run; any 00 symbol returns to S0.
  always_comb
    det_n = !(a | b)    ? S0 :
            det == S0   ? ((a ^ b) ? S1 : S0) :
            det == S1   ? ((a & b) ? S2 : S1) : S3;
  always_ff @(posedge clk or posedge reset)
    if (reset) det <= S0;
    else det <= det_n;
  assign y_exp = det == S1 || det == S2;
`endif
endmodule
